// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types, constants and CRC5 helper for the USB TX packet builder.
package usb_tx_pkg;
    typedef enum logic [1:0] {PT_HANDSHAKE, PT_TOKEN, PT_DATA, PT_RESERVED} pkt_type_t;
    typedef enum logic [3:0] {
        S_IDLE, S_SYNC, S_PID, S_TOK0, S_TOK1, S_DATA, S_CRC_LO, S_CRC_HI, S_DONE
    } state_t;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [4:0]  CRC5_POLY  = 5'h05;
    localparam logic [4:0]  CRC5_INIT  = 5'h1F;
    localparam logic [15:0] CRC16_POLY = 16'hA001;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // Token CRC over {endp, addr}, LSB first, complemented on the way out.
    function automatic logic [4:0] crc5(input logic [10:0] d);
        logic [4:0] c;
        c = CRC5_INIT;
        for (int i = 0; i < 11; i++)
            c = (c[4] ^ d[i]) ? {c[3:0], 1'b0} ^ CRC5_POLY : {c[3:0], 1'b0};
        return ~c;
    endfunction
endpackage

// File: rtl/usb_tx_packet_builder_crc16.sv
// usb_crc16_byte: combinational CRC16 (reflected 0xA001) update over one byte, LSB first.
module usb_crc16_byte
    import usb_tx_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  byte_in,
    output logic [15:0] crc_out
);
    logic [15:0] c;

    always_comb begin
        c = crc_in ^ {8'h00, byte_in};
        for (int i = 0; i < 8; i++)
            c = c[0] ? (c >> 1) ^ CRC16_POLY : c >> 1;
    end

    assign crc_out = c;
endmodule

// File: rtl/usb_tx_packet_builder.sv
// usb_tx_packet_builder: assembles SYNC/PID/token-or-payload/CRC into a flat byte vector.
module usb_tx_packet_builder
    import usb_tx_pkg::*;
#(
    parameter int MAX_DATA_BYTES = 64,
    parameter int PKT_W          = 8*(MAX_DATA_BYTES+4),
    parameter int CNT_W          = $clog2(MAX_DATA_BYTES+5)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       pkt_type,
    input  logic [3:0]       pid,
    input  logic [10:0]      token_field,
    input  logic [CNT_W-1:0] data_count,
    output logic             buf_req,
    input  logic [7:0]       buf_data,
    input  logic             buf_empty,
    output logic [PKT_W-1:0] packet,
    output logic [CNT_W-1:0] packet_bytes,
    output logic             busy,
    output logic             done,
    output logic             err
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DATA_BYTES);

    state_t           state;
    pkt_type_t        cmd_type;
    logic [3:0]       cmd_pid;
    logic [10:0]      cmd_tok;
    logic [CNT_W-1:0] cmd_cnt, req_cnt, wr_cnt;
    logic [15:0]      crc, crc_next;
    logic             rd_valid, abort, wr_en;
    logic [7:0]       wr_byte;

    usb_crc16_byte u_crc (.crc_in(crc), .byte_in(buf_data), .crc_out(crc_next));

    assign busy    = state != S_IDLE;
    assign buf_req = state == S_DATA && req_cnt < cmd_cnt && !buf_empty;
    assign abort   = state == S_DATA && req_cnt < cmd_cnt && buf_empty;

    always_comb begin
        wr_en   = 1'b1;
        wr_byte = 8'h00;
        case (state)
            S_PID:    wr_byte = {~cmd_pid, cmd_pid};
            S_TOK0:   wr_byte = cmd_tok[7:0];
            S_TOK1:   wr_byte = {crc5(cmd_tok), cmd_tok[10:8]};
            S_DATA: begin
                wr_byte = buf_data;
                wr_en   = rd_valid && !abort;
            end
            S_CRC_LO: wr_byte = ~crc[7:0];
            S_CRC_HI: wr_byte = ~crc[15:8];
            default:  wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            packet       <= '0;
            packet_bytes <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            rd_valid     <= 1'b0;
            req_cnt      <= '0;
            wr_cnt       <= '0;
            crc          <= CRC16_INIT;
            cmd_type     <= PT_HANDSHAKE;
            cmd_pid      <= '0;
            cmd_tok      <= '0;
            cmd_cnt      <= '0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            rd_valid <= buf_req;
            if (wr_en) begin
                packet[{packet_bytes, 3'b000} +: 8] <= wr_byte;
                packet_bytes <= packet_bytes + 1'b1;
            end
            case (state)
                S_IDLE: if (start) begin
                    if (pkt_type == PT_RESERVED || (pkt_type == PT_DATA && data_count > MAX_CNT)) begin
                        err <= 1'b1;
                    end else begin
                        cmd_type <= pkt_type_t'(pkt_type);
                        cmd_pid  <= pid;
                        cmd_tok  <= token_field;
                        cmd_cnt  <= data_count;
                        state    <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    packet       <= {{(PKT_W-8){1'b0}}, SYNC_BYTE};
                    packet_bytes <= CNT_W'(1);
                    crc          <= CRC16_INIT;
                    req_cnt      <= '0;
                    wr_cnt       <= '0;
                    state        <= S_PID;
                end
                S_PID: begin
                    done  <= cmd_type == PT_HANDSHAKE;
                    state <= cmd_type == PT_HANDSHAKE ? S_DONE :
                             cmd_type == PT_TOKEN     ? S_TOK0 :
                             cmd_cnt != '0            ? S_DATA : S_CRC_LO;
                end
                S_TOK0: state <= S_TOK1;
                S_TOK1: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DATA: if (abort) begin
                    err   <= 1'b1;
                    state <= S_IDLE;
                end else begin
                    if (buf_req) req_cnt <= req_cnt + 1'b1;
                    // buf_data belongs to the request issued last cycle
                    if (rd_valid) begin
                        crc    <= crc_next;
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt + 1'b1 == cmd_cnt) state <= S_CRC_LO;
                    end
                end
                S_CRC_LO: state <= S_CRC_HI;
                S_CRC_HI: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_usb_tx_packet_builder.sv
// tb_usb_tx_packet_builder: directed self-checking bench for usb_tx_packet_builder.
module tb_usb_tx_packet_builder;
    localparam int MAX   = 64;
    localparam int PKT_W = 8*(MAX+4);
    localparam int CNT_W = $clog2(MAX+5);

    logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [1:0]       pkt_type = '0;
    logic [3:0]       pid = '0;
    logic [10:0]      token_field = '0;
    logic [CNT_W-1:0] data_count = '0;
    logic             buf_req, buf_empty = 1'b0;
    logic [7:0]       buf_data = '0;
    logic [PKT_W-1:0] packet;
    logic [CNT_W-1:0] packet_bytes;
    logic             busy, done, err;

    int errors = 0, checks = 0;
    logic [7:0] payload [MAX];
    int done_cyc, err_cyc, reqs;
    bit overlap, busy_seen;

    always #5 clk = ~clk;

    usb_tx_packet_builder #(.MAX_DATA_BYTES(MAX)) dut (
        .clk(clk), .rst(rst), .start(start), .pkt_type(pkt_type), .pid(pid),
        .token_field(token_field), .data_count(data_count), .buf_req(buf_req),
        .buf_data(buf_data), .buf_empty(buf_empty), .packet(packet),
        .packet_bytes(packet_bytes), .busy(busy), .done(done), .err(err)
    );

    // Independent shift-register form: taps at bit 0 and bit 2 (x^5+x^2+1).
    function automatic logic [4:0] crc5_model(input logic [10:0] d);
        logic [4:0] c;
        logic fb;
        c = 5'h1F;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ d[i];
            c  = {c[3], c[2], c[1] ^ fb, c[0], fb};
        end
        return ~c;
    endfunction

    function automatic logic [15:0] crc16_model(input int n);
        logic [15:0] c;
        logic fb;
        c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ payload[i][b];
                c  = {1'b0, c[15:1]};
                if (fb) c = c ^ 16'hA001;
            end
        return c;
    endfunction

    // Cycle 0 is the cycle start is high; k counts cycles after it. Acts as the TX buffer.
    task automatic run_pkt(input logic [1:0] t, input logic [3:0] p, input logic [10:0] tok,
                           input int n, input int empty_after, input int restart_cyc);
        int idx;
        bit pend;
        done_cyc = -1; err_cyc = -1; reqs = 0; overlap = 0; busy_seen = 0; idx = 0; pend = 0;
        @(negedge clk);
        pkt_type = t; pid = p; token_field = tok; data_count = CNT_W'(n); start = 1'b1; buf_empty = 1'b0;
        for (int k = 1; k <= 200 && done_cyc < 0 && err_cyc < 0; k++) begin
            @(posedge clk);
            #1;
            start = (k == restart_cyc);
            if (k == restart_cyc) begin pkt_type = 2'd0; pid = 4'hA; end
            if (pend && idx < MAX) begin buf_data = payload[idx]; idx++; end
            buf_empty = reqs >= empty_after;
            @(negedge clk);
            pend = buf_req;
            if (buf_req) reqs++;
            if (buf_req && done) overlap = 1;
            if (busy) busy_seen = 1;
            if (done) done_cyc = k;
            if (err) err_cyc = k;
        end
        start = 1'b0; buf_empty = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; pkt_type = 2'd0; pid = 4'h2;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (packet !== '0) begin errors++; $display("FAIL reset_packet got=%h want=0", packet); end
        checks++; if (packet_bytes !== '0) begin errors++; $display("FAIL reset_bytes got=%0d want=0", packet_bytes); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err); end
        checks++; if (buf_req !== 1'b0) begin errors++; $display("FAIL reset_buf_req got=%b want=0", buf_req); end
        start = 1'b0; rst = 1'b0;
    endtask

    task automatic test_handshake(input logic [3:0] p, input logic [15:0] want);
        run_pkt(2'd0, p, 11'd0, 0, 99, 0);
        checks++; if (done_cyc != 3) begin errors++; $display("FAIL hs_done_cycle got=%0d want=3", done_cyc); end
        checks++; if (packet[15:0] !== want) begin errors++; $display("FAIL hs_bytes got=%h want=%h", packet[15:0], want); end
        checks++; if (packet_bytes !== CNT_W'(2)) begin errors++; $display("FAIL hs_count got=%0d want=2", packet_bytes); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_idle_after got=%b want=0", busy); end
    endtask

    task automatic test_token;
        run_pkt(2'd1, 4'h1, {4'hE, 7'h15}, 0, 99, 0);
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL tok_done_cycle got=%0d want=5", done_cyc); end
        checks++; if (packet[31:0] !== 32'hBF15E180) begin errors++; $display("FAIL tok_bytes got=%h want=BF15E180", packet[31:0]); end
        checks++; if (packet[PKT_W-1:32] !== '0) begin errors++; $display("FAIL tok_upper_clear got=%h want=0", packet[PKT_W-1:32]); end
        checks++; if (packet_bytes !== CNT_W'(4)) begin errors++; $display("FAIL tok_count got=%0d want=4", packet_bytes); end
    endtask

    task automatic test_busy_start;
        logic [10:0] tok;
        logic [31:0] want;
        tok  = {4'h3, 7'h7F};
        want = {crc5_model(tok), tok[10:8], tok[7:0], 8'h69, 8'h80};
        run_pkt(2'd1, 4'h9, tok, 0, 99, 2);
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL busy_start_done got=%0d want=5", done_cyc); end
        checks++; if (err_cyc != -1) begin errors++; $display("FAIL busy_start_err got=%0d want=-1", err_cyc); end
        checks++; if (packet[31:0] !== want) begin errors++; $display("FAIL busy_start_bytes got=%h want=%h", packet[31:0], want); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle got=%b want=0", busy); end
    endtask

    task automatic test_data_zero;
        run_pkt(2'd2, 4'h3, 11'd0, 0, 99, 0);
        checks++; if (done_cyc != 5) begin errors++; $display("FAIL d0_done_cycle got=%0d want=5", done_cyc); end
        checks++; if (packet[31:0] !== 32'h0000C380) begin errors++; $display("FAIL d0_bytes got=%h want=0000C380", packet[31:0]); end
        checks++; if (packet_bytes !== CNT_W'(4)) begin errors++; $display("FAIL d0_count got=%0d want=4", packet_bytes); end
        checks++; if (reqs != 0) begin errors++; $display("FAIL d0_reqs got=%0d want=0", reqs); end
    endtask

    task automatic test_data_max;
        logic [15:0] c;
        run_pkt(2'd2, 4'hB, 11'd0, MAX, 999, 0);
        c = crc16_model(MAX);
        checks++; if (done_cyc != MAX + 6) begin errors++; $display("FAIL dmax_done_cycle got=%0d want=%0d", done_cyc, MAX + 6); end
        checks++; if (packet_bytes !== CNT_W'(MAX + 4)) begin errors++; $display("FAIL dmax_count got=%0d want=%0d", packet_bytes, MAX + 4); end
        checks++; if (reqs != MAX) begin errors++; $display("FAIL dmax_reqs got=%0d want=%0d", reqs, MAX); end
        checks++; if (overlap) begin errors++; $display("FAIL dmax_req_with_done got=1 want=0"); end
        checks++; if (packet[15:0] !== 16'h4B80) begin errors++; $display("FAIL dmax_header got=%h want=4B80", packet[15:0]); end
        for (int i = 0; i < MAX; i++) begin
            checks++;
            if (packet[8*(i+2) +: 8] !== payload[i]) begin
                errors++; $display("FAIL dmax_byte%0d got=%h want=%h", i + 2, packet[8*(i+2) +: 8], payload[i]);
            end
        end
        checks++; if (packet[8*(MAX+2) +: 8] !== ~c[7:0]) begin errors++; $display("FAIL dmax_crc_lo got=%h want=%h", packet[8*(MAX+2) +: 8], ~c[7:0]); end
        checks++; if (packet[8*(MAX+3) +: 8] !== ~c[15:8]) begin errors++; $display("FAIL dmax_crc_hi got=%h want=%h", packet[8*(MAX+3) +: 8], ~c[15:8]); end
    endtask

    task automatic test_abort;
        run_pkt(2'd2, 4'h3, 11'd0, 8, 3, 0);
        checks++; if (err_cyc != 7) begin errors++; $display("FAIL abort_err_cycle got=%0d want=7", err_cyc); end
        checks++; if (done_cyc != -1) begin errors++; $display("FAIL abort_done got=%0d want=-1", done_cyc); end
        checks++; if (reqs != 3) begin errors++; $display("FAIL abort_reqs got=%0d want=3", reqs); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b want=0", busy); end
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err_width got=%b want=0", err); end
        checks++; if (buf_req !== 1'b0) begin errors++; $display("FAIL abort_buf_req got=%b want=0", buf_req); end
        test_handshake(4'hD, 16'h2D80);
    endtask

    task automatic test_reject;
        run_pkt(2'd3, 4'h2, 11'd0, 0, 99, 0);
        checks++; if (err_cyc != 1) begin errors++; $display("FAIL rej_type_err got=%0d want=1", err_cyc); end
        checks++; if (busy_seen) begin errors++; $display("FAIL rej_type_busy got=1 want=0"); end
        run_pkt(2'd2, 4'h3, 11'd0, MAX + 1, 999, 0);
        checks++; if (err_cyc != 1) begin errors++; $display("FAIL rej_len_err got=%0d want=1", err_cyc); end
        checks++; if (busy_seen) begin errors++; $display("FAIL rej_len_busy got=1 want=0"); end
        checks++; if (reqs != 0) begin errors++; $display("FAIL rej_len_reqs got=%0d want=0", reqs); end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        pkt_type = 2'd2; pid = 4'h3; data_count = CNT_W'(8); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b want=0", busy); end
        checks++; if (buf_req !== 1'b0) begin errors++; $display("FAIL rmid_buf_req got=%b want=0", buf_req); end
        checks++; if (packet_bytes !== '0) begin errors++; $display("FAIL rmid_count got=%0d want=0", packet_bytes); end
        checks++; if (packet !== '0) begin errors++; $display("FAIL rmid_packet got=%h want=0", packet); end
        rst = 1'b0;
        test_handshake(4'h5, 16'hA580);
    endtask

    initial begin
        for (int i = 0; i < MAX; i++) payload[i] = 8'(i + 1);
        test_reset;
        test_handshake(4'h2, 16'hD280);
        test_token;
        test_busy_start;
        test_data_zero;
        test_data_max;
        test_abort;
        test_reject;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/usb_tx_packet_builder.md
# usb_tx_packet_builder

Parametrised USB transmit packet builder that assembles a complete, wire-ordered packet (SYNC, PID, token field or payload, CRC) into a flat byte vector for the TX serialiser. It sits between the TX protocol controller, which issues a start command with packet type and PID, and the TX data buffer, which it drains byte by byte for DATA packets. It generates CRC5 (tokens) and CRC16 (data) in hardware and reports completion or error with single-cycle pulses.

## Interface
- MAX_DATA_BYTES, 64, maximum payload bytes per DATA packet
- PKT_W, 8*(MAX_DATA_BYTES+4), packet vector width (SYNC+PID+payload+CRC16)
- CNT_W, $clog2(MAX_DATA_BYTES+5), width of byte counts

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset; synchronous and active-high
- start  in  1  command pulse, sampled only in IDLE
- pkt_type  in  2  0 HANDSHAKE, 1 TOKEN, 2 DATA, 3 reserved
- pid  in  4  PID nibble; emitted byte is {~pid, pid}
- token_field  in  11  {endp[3:0], addr[6:0]}
- data_count  in  CNT_W  payload bytes to fetch (DATA only)
- buf_req  out  1  request one byte from TX buffer
- buf_data  in  8  buffer byte, valid the cycle after buf_req
- buf_empty  in  1  buffer has no byte available
- packet  out  PKT_W  assembled packet; byte k at bits [8k+7:8k]
- packet_bytes  out  CNT_W  bytes written so far
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse, packet complete and stable
- err  out  1  one-cycle pulse, command rejected or aborted

## Operation
- States: IDLE, SYNC, PID, TOK0, TOK1, DATA, CRC_LO, CRC_HI, DONE.
- Each write state writes one byte at index packet_bytes and increments packet_bytes.
- IDLE: start with legal command -> SYNC. pkt_type 3, or DATA with data_count > MAX_DATA_BYTES -> err next cycle, remain IDLE. start while busy ignored.
- SYNC: clears all of packet, writes 8'h80 at byte 0, packet_bytes=1; CRC16 register loaded 16'hFFFF.
- PID -> DONE (HANDSHAKE), TOK0 (TOKEN), DATA (DATA, data_count>0) or CRC_LO (DATA, data_count=0).
- TOK0 writes token_field[7:0]; TOK1 writes {crc5, token_field[10:8]}. CRC5: poly x^5+x^2+1, init 5'h1F, LSB-first over 11 bits, complemented.
- DATA: buf_req high while req_cnt < data_count and buf_empty low; every buf_data arriving the cycle after a req is written and fed to CRC16. Exit to CRC_LO when wr_cnt == data_count.
- buf_empty high in DATA while req_cnt < data_count -> abort: err next cycle, IDLE, buf_req low; packet contents undefined, packet_bytes holds.
- CRC16: poly 0x8005 reflected (0xA001), init 16'hFFFF, LSB-first; CRC_LO writes ~crc[7:0], CRC_HI writes ~crc[15:8].
- DONE: done=1 for one cycle, then IDLE; packet and packet_bytes hold until next SYNC.

## Timing
- Reset values: packet 0, packet_bytes 0, busy 0, done 0, err 0, buf_req 0; state IDLE.
- rst mid-packet: reset values next cycle; in-flight buffer byte discarded.
- start sampled in cycle 0: SYNC in cycle 1, PID in cycle 2.
- HANDSHAKE: done in cycle 3, packet_bytes=2.
- TOKEN: TOK0 cycle 3, TOK1 cycle 4, done cycle 5, packet_bytes=4.
- DATA, n bytes, no stalls: buf_req cycles 3..2+n, DATA occupies 3..3+n, CRC_LO 4+n, CRC_HI 5+n, done 6+n, packet_bytes=n+4. n=0: CRC_LO 3, done 5.
- buf_req and done never high in the same cycle; err never coincides with done.

## Structure
- Package usb_tx_pkg: pkt_type enum, state enum, SYNC_BYTE 8'h80, CRC5/CRC16 polynomials and init values.
- Sub-module usb_crc16_byte: byte-wide combinational CRC16 update (crc_in, byte_in -> crc_out); register stays in the builder. CRC5 is computed inline.

## Test plan
- Reset with start held high -> all outputs at reset values, no buf_req; after release, one HANDSHAKE pid=4'h2 -> packet bytes 80 D2, packet_bytes=2, done in cycle 3.
- TOKEN pid=4'h1, addr=7'h15, endp=4'hE -> bytes 80 E1 15 then {5'h17 field, endp[3:1]} per golden CRC5 model, done in cycle 5.
- DATA pid=4'h3, n=0 -> bytes 80 C3 00 00, packet_bytes=4, no buf_req, done in cycle 5.
- DATA n=MAX_DATA_BYTES, incrementing bytes -> bytes 2..65 equal payload, CRC bytes equal bit-serial golden model, packet_bytes=68, done in cycle 70.
- DATA n=8, buf_empty rises after 3 requests -> err pulse, IDLE, buf_req low; next HANDSHAKE completes normally.
- pkt_type=3 or data_count=MAX+1 -> err one cycle later, busy stays 0; start while busy -> ignored, current packet unaffected.
